// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder
//   Multi-cycle unsigned adder: {cout, sum} = a + b + cin, computed one W-bit
//   chunk per cycle over K = N/W cycles through a single (W+1)-bit adder, with
//   a carry register chaining the chunks.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; a, b, cin sampled on the accept edge
//   a, b [N-1:0], cin   operands and carry-in
//   out_valid/out_ready result handshake; sum/cout held while out_ready is low
//   sum [N-1:0], cout   result and carry out of bit N-1
//   busy                high whenever an operation is in flight or waiting
module seq_chunk_adder #(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [W:0]    chunk;
    logic          last_chunk;

    // The only adder in the block: low chunk of each operand plus running carry.
    assign chunk      = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + {{W{1'b0}}, carry_q};
    assign last_chunk = (cnt_q == CW'(K - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> W;
                b_d     = b_q >> W;
                // New chunk enters at the top; after K shifts chunk 0 sits at [W-1:0].
                sum_d   = {chunk[W-1:0], sum_q[N-1:W]};
                carry_d = chunk[W];
                cnt_d   = cnt_q + CW'(1);
                if (last_chunk) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs are pure state decodes, so in_ready is 1 during reset.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Multi-cycle N-bit adder that sequences one narrow W-bit adder stage over N/W cycles, with a carry register linking the chunks. It sits between an operand producer and a result consumer, using valid/ready handshakes on both sides. It trades latency for area where a full-width single-cycle N-bit adder is too large or too slow. The result is bit-identical to the full-width sum {cout,sum} = a + b + cin.

## Interface
- N, 64, operand and sum width in bits; must be a multiple of W.
- W, 16, chunk width, i.e. the width of the internal adder stage; N/W must be at least 2.
- K (localparam), N/W, number of chunk cycles per operation.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand source has a, b and cin valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  N  operand A; sampled on the accept edge.
- b  in  N  operand B; sampled on the accept edge.
- cin  in  1  carry-in; sampled on the accept edge.
- out_valid  out  1  sum and cout hold a valid result.
- out_ready  in  1  consumer accepts the result.
- sum  out  N  result bits [N-1:0].
- cout  out  1  carry out of bit N-1.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, RUN, DONE. The state is encoded in registers.
- **IDLE:**
  - in_ready=1.
  - On in_valid && in_ready:
    - latch a and b into operand shift registers;
    - load the carry register with cin;
    - clear the chunk counter to 0;
    - go to RUN.
- **RUN, one chunk per cycle:**
  - Compute {c, s} = a_reg[W-1:0] + b_reg[W-1:0] + carry, using a (W+1)-bit result.
  - Shift a_reg and b_reg right by W.
  - Shift s into sum_reg from the top; sum_reg shifts right by W, so chunk 0 ends in bits [W-1:0].
  - carry <= c; counter increments.
  - When the counter reaches K-1, the update on that edge is the final chunk; go to DONE.
- **DONE:**
  - out_valid=1.
  - sum=sum_reg and cout=carry, both held stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE.
- **Widths:**
  - The counter is clog2(K) bits, with a minimum of 1 bit.
  - Arithmetic is unsigned. The only overflow path is cout; nothing is truncated or saturated.
- **Backpressure and input rules:**
  - in_valid is ignored outside IDLE.
  - a, b and cin may change freely after the accept edge.
- **Output validity:** sum and cout are meaningful only while out_valid=1. During RUN, sum shows partial shift-register contents.
- **Reset (rst_n=0, at any time including mid-RUN or in DONE):**
  - state goes to IDLE immediately; the in-flight operation is discarded and produces no out_valid.
  - sum_reg, carry, the counter and the operand registers all clear to 0.

## Timing
- **Reset values:**
  - in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - in_ready is decoded from the state, so it is 1 while in reset.
- **Latency:**
  - The accept edge is E0.
  - out_valid rises after edge E0+K (K RUN cycles). For N=64, W=16: 4 cycles.
  - out_valid then stays high until the handshake edge.
- **Throughput:**
  - One operation per K+2 cycles at best: accept edge, K RUN edges, DONE handshake edge, then a new accept in the following IDLE cycle.
  - Accept is not overlapped with DONE.
- **Simultaneous events:**
  - An out_ready=1 arriving in the same cycle that DONE is entered has no effect until the state is DONE.
  - An out_valid && out_ready edge moves the state to IDLE; in_ready=1 from the next cycle.
- **Boundary cases:** both all-ones operands with cin=1, and all-zero operands, follow the same K-cycle path. There is no early termination.

## Test plan
1. **Reset values.** Assert rst_n=0 for 3 cycles, then release.
   - Required: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
2. **Full carry ripple.** With N=64, W=16, apply a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0.
   - Required: sum=0, cout=1.
   - Required: out_valid rises exactly 4 cycles after the accept edge.
3. **Chunk-boundary carries.** Apply a=0x0000_FFFF_0000_FFFF, b=0x0000_0001_0000_0001, cin=1.
   - Required: sum=0x0001_0000_0001_0001, cout=0.
4. **Backpressure.** Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands.
   - Required: sum and cout are stable, in_ready=0, and the new operands are not accepted.
   - Release out_ready. Required: IDLE and in_ready=1 on the next cycle.
5. **Reset mid-operation.** Accept a=5, b=7, then drop rst_n for 1 cycle after 2 RUN cycles.
   - Required: out_valid never rises for that operation.
   - A subsequent a=5, b=7 request yields sum=12, cout=0.
6. **Random regression.** Run 10,000 random (a, b, cin) operations with randomized in_valid and out_ready stalls.
   - Required: every result equals a+b+cin as an (N+1)-bit value.
   - Required: no lost or duplicated results.
   - Repeat with W=8 and W=32.
